apb_mem_slave: RTL and testbench

APB completer that backs one PSEL slot with a byte-organised, 32-bit-wide RAM and programmable wait states. Each of the four slots on the system APB bus has its own instance, selected by `PSEL[n]`. The block is the memory model behind the APB master BFM in block-level simulation, and it must also be synthesizable as a scratch-pad RAM.

---
 rtl/apb_mem_slave.sv | 152 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer backed by a zero-initialised, byte-lane 32-bit RAM; APB_AMBA4_EN adds PPROT/PSTRB.
// Latency: 2 + DELAY cycles per transfer (setup + DELAY wait cycles + one ready cycle).
// Backpressure: PREADY held low for DELAY access cycles; dropping PSEL early aborts with no write.
module apb_mem_slave #(
    parameter int unsigned SIZE_IN_BYTES = 1024,
    parameter int unsigned DELAY         = 0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
`ifdef APB_AMBA4_EN
    input  logic [2:0]  PPROT,
    input  logic [3:0]  PSTRB,
`endif
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int AW    = $clog2(SIZE_IN_BYTES);
    localparam int WORDS = SIZE_IN_BYTES / 4;
    localparam int IW    = (AW > 2) ? AW - 2 : 1;

    // The setup cycle is spent in ST_IDLE: the setup edge already decides WAIT or READY,
    // so a DELAY of 0 raises PREADY in the very first access cycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;

    logic [31:0] mem_q [WORDS] = '{default: '0};

    logic [IW-1:0] idx;
    logic          addr_err;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [3:0]    strb;
    logic          wr_en;
    logic          unused_sig;

`ifdef APB_AMBA4_EN
    assign strb       = PSTRB;
    assign unused_sig = ^{PPROT, PADDR[31:AW]};
`else
    assign strb       = 4'hF;
    assign unused_sig = ^PADDR[31:AW];
`endif

    assign idx      = IW'(PADDR[AW-1:0] >> 2);
    assign addr_err = (PADDR[1:0] != 2'b00);
    assign rd_word  = mem_q[idx];

    always_comb begin
        wr_word = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) wr_word[8*k +: 8] = PWDATA[8*k +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    err_d = addr_err;
                    cnt_d = 8'(DELAY);
                    if (DELAY == 0) begin
                        state_d   = ST_READY;
                        pready_d  = 1'b1;
                        pslverr_d = addr_err;
                        if (!PWRITE) prdata_d = addr_err ? 32'h0 : rd_word;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q <= 8'd1) begin
                    state_d   = ST_READY;
                    cnt_d     = 8'd0;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    if (!PWRITE) prdata_d = err_q ? 32'h0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_READY: begin
                if (!PSEL || PENABLE) begin
                    wr_en     = PSEL && PWRITE && !err_q;
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Storage survives reset; wr_en is already blocked while the control flops are held in reset.
    always_ff @(posedge PCLK) begin
        if (wr_en) mem_q[idx] <= wr_word;
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (DELAY 0/3/2) on a shared bus, table vectors,
// hand-written wait/reset sequences and random transfers against a byte-array memory model.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
`ifdef APB_AMBA4_EN
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    localparam logic [31:0] EXP_STRB = 32'hFFBBFFDD;
    localparam logic [31:0] EXP_ZERO = 32'h12345678;
`else
    localparam logic [31:0] EXP_STRB = 32'hAABBCCDD;
    localparam logic [31:0] EXP_ZERO = 32'h00000000;
`endif
    logic [2:0][31:0] prdata;
    logic [2:0]       pready;
    logic [2:0]       pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [3][1024];

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_slave #(
            .SIZE_IN_BYTES(1024),
            .DELAY((g == 0) ? 0 : (g == 1) ? 3 : 2)
        ) u_dut (
            .PCLK   (pclk),
            .PRESETn(presetn),
            .PSEL   (psel[g]),
            .PADDR  (paddr),
            .PENABLE(penable),
            .PWRITE (pwrite),
            .PWDATA (pwdata),
`ifdef APB_AMBA4_EN
            .PPROT  (pprot),
            .PSTRB  (pstrb),
`endif
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int dly_of(input int inst);
        return (inst == 0) ? 0 : (inst == 1) ? 3 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed array, address wraps at 1 KiB, misaligned => error, no update.
    task automatic model_xfer(input int inst, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              output logic [31:0] rd, output logic err);
        int off;
        logic [3:0] s;
        off = int'(addr % 1024);
        err = (addr % 4) != 0;
        rd  = 32'h0;
`ifdef APB_AMBA4_EN
        s = strb;
`else
        s = 4'hF;
`endif
        if (!err) begin
            for (int k = 0; k < 4; k++) begin
                if (wr && s[k]) mdl[inst][off + k] = wdata[8*k +: 8];
                rd[8*k +: 8] = mdl[inst][off + k];
            end
            if (wr) rd = 32'h0;
        end
    endtask

    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err);
        int waits;
        logic [31:0] prev;
        prev = prdata[inst];
        @(negedge pclk);
        psel = 3'b000;
        psel[inst] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wdata;
`ifdef APB_AMBA4_EN
        pstrb = strb;
`endif
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        while (!pready[inst] && waits < 300) begin
            @(negedge pclk);
            waits++;
        end
        chk("wait_states", waits, dly_of(inst));
        rd  = prdata[inst];
        err = pslverr[inst];
        if (wr) chk("prdata_hold_on_write", rd, prev);
        @(negedge pclk);
        psel = 3'b000;
        penable = 1'b0;
        chk("ready_err_drop", {30'h0, pready[inst], pslverr[inst]}, 32'h0);
    endtask

    task automatic checked_xfer(input int inst, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] rd, exp_rd;
        logic err, exp_err;
        model_xfer(inst, wr, addr, wdata, strb, exp_rd, exp_err);
        xfer(inst, wr, addr, wdata, strb, rd, err);
        chk("rand_pslverr", {31'h0, err}, {31'h0, exp_err});
        if (!wr) chk("rand_prdata", rd, exp_rd);
    endtask

    task automatic abort_xfer(input int inst, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge pclk);
        psel = 3'b000;
        psel[inst] = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = addr;
        pwdata = wdata;
`ifdef APB_AMBA4_EN
        pstrb = 4'hF;
`endif
        @(negedge pclk);
        penable = 1'b1;
        chk("abort_ready_low", {31'h0, pready[inst]}, 32'h0);
        @(negedge pclk);
        psel = 3'b000;
        penable = 1'b0;
        @(negedge pclk);
        chk("abort_ready_idle", {31'h0, pready[inst]}, 32'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd;
        logic err, merr;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'h12345678, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'h12345678, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, EXP_STRB, 1'b0};
        tbl[5]  = '{1'b1, 32'h0001_0004, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0404, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0012, 32'h00000001, 4'hF, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'h12345678, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0013, 32'h0,        4'hF, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_0010, 32'h0,        4'h0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, EXP_ZERO, 1'b0};
        tbl[13] = '{1'b0, 32'h0000_03FC, 32'h0,        4'hF, 32'h0, 1'b0};

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 1024; j++) mdl[i][j] = 8'h00;

        presetn = 1'b0;
        psel = 3'b000;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 32'h0;
        pwdata = 32'h0;
`ifdef APB_AMBA4_EN
        pprot = 3'b010;
        pstrb = 4'hF;
`endif
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_prdata", prdata[i], 32'h0);
            chk("reset_ready_err", {30'h0, pready[i], pslverr[i]}, 32'h0);
        end
        presetn = 1'b1;

        // DELAY=3 read of fresh memory: 3 low access cycles then one ready cycle.
        xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, err);
        chk("d3_read_prdata", rd, 32'h0);
        chk("d3_read_err", {31'h0, err}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            model_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, mrd, merr);
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, err);
            chk($sformatf("vec%0d_pslverr", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            if (!tbl[i].wr) chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
        end

        // DELAY=2: reset hits the first wait cycle of a write; memory must keep old data.
        checked_xfer(2, 1'b1, 32'h8, 32'h11112222, 4'hF);
        checked_xfer(2, 1'b0, 32'h8, 32'h0, 4'hF);
        @(negedge pclk);
        psel = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h8;
        pwdata = 32'h55;
`ifdef APB_AMBA4_EN
        pstrb = 4'hF;
`endif
        @(negedge pclk);
        penable = 1'b1;
        chk("rst_mid_ready_before", {31'h0, pready[2]}, 32'h0);
        presetn = 1'b0;
        #1;
        chk("rst_mid_prdata", prdata[2], 32'h0);
        chk("rst_mid_ready_err", {30'h0, pready[2], pslverr[2]}, 32'h0);
        @(negedge pclk);
        psel = 3'b000;
        penable = 1'b0;
        presetn = 1'b1;
        xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, rd, err);
        chk("rst_mid_mem_kept", rd, 32'h11112222);

        // Aborted writes on the waited instances must leave memory untouched.
        abort_xfer(1, 32'h0, 32'hDEADBEEF);
        checked_xfer(1, 1'b0, 32'h0, 32'h0, 4'hF);
        abort_xfer(2, 32'h8, 32'hDEADBEEF);
        checked_xfer(2, 1'b0, 32'h8, 32'h0, 4'hF);

        // Back-to-back read-after-write on every instance.
        for (int i = 0; i < 3; i++) begin
            checked_xfer(i, 1'b1, 32'h3C, 32'hA5A50000 + 32'(i), 4'hF);
            checked_xfer(i, 1'b0, 32'h3C, 32'h0, 4'hF);
        end

        for (int n = 0; n < 300; n++) begin
            int inst;
            logic wr;
            logic [31:0] addr;
            inst = $urandom_range(0, 2);
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 10)
                 | ($urandom_range(0, 1) << 20);
            if ($urandom_range(0, 7) == 0) addr = addr | $urandom_range(1, 3);
            if (inst != 0 && $urandom_range(0, 9) == 0)
                abort_xfer(inst, addr, $urandom);
            else
                checked_xfer(inst, wr, addr, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
